alu_seq: RTL and testbench

Sequencing front-end for the 4-bit combinational ALU. Accepts operation commands over a valid/ready handshake and registers the operands into the ALU. It captures the 4-bit result plus overflow/borrow bit and returns them over a second valid/ready handshake. A 4-bit accumulator holds the last result so command chains (e.g. running sums) can be issued without the host tracking intermediate values.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_seq_if.sv | 39 +++
 rtl/alu_core.sv | 27 ++
 rtl/alu_seq.sv | 101 ++++++++++
 tb/tb_alu_seq.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared constants, opcode encodings, FSM state type and ALU result payload
// for the alu_seq block.
package alu_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned SEL_W  = 3;

    localparam logic [SEL_W-1:0] OP_ADD = 3'b000;
    localparam logic [SEL_W-1:0] OP_SUB = 3'b001;
    localparam logic [SEL_W-1:0] OP_AND = 3'b010;
    localparam logic [SEL_W-1:0] OP_OR  = 3'b011;
    localparam logic [SEL_W-1:0] OP_XOR = 3'b100;
    localparam logic [SEL_W-1:0] OP_SHL = 3'b101;
    localparam logic [SEL_W-1:0] OP_SHR = 3'b110;
    localparam logic [SEL_W-1:0] OP_ROL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // ALU result: carry/borrow bit on top of the data word
    typedef struct packed {
        logic              ov;
        logic [DATA_W-1:0] out;
    } alu_res_t;

endpackage

// File: rtl/alu_seq_if.sv
// Command/response handshake bundle for alu_seq.
// ALU_SEQ_ZERO_FLAG_EN adds the rsp_zero response flag.
interface alu_seq_if;
    import alu_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [SEL_W-1:0]  cmd_sel;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic              cmd_acc;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_out;
    logic              rsp_ov;
    logic [DATA_W-1:0] acc;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic              rsp_zero;
`endif

    // Host side
    modport master (
        output cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_acc, rsp_ready,
`ifdef ALU_SEQ_ZERO_FLAG_EN
        input  rsp_zero,
`endif
        input  cmd_ready, rsp_valid, rsp_out, rsp_ov, acc
    );

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_acc, rsp_ready,
`ifdef ALU_SEQ_ZERO_FLAG_EN
        output rsp_zero,
`endif
        output cmd_ready, rsp_valid, rsp_out, rsp_ov, acc
    );

endinterface

// File: rtl/alu_core.sv
// Purely combinational 4-bit ALU; result is {ov, out}.
module alu_core
    import alu_pkg::*;
(
    input  logic [SEL_W-1:0]  sel,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output alu_res_t          res
);

    // Opcode decode; ov is only meaningful for add/sub and zero otherwise
    always_comb begin
        res = '0;
        case (sel)
            OP_ADD: res = alu_res_t'({1'b0, a} + {1'b0, b});
            OP_SUB: res = alu_res_t'({1'b0, a} - {1'b0, b});
            OP_AND: res.out = a & b;
            OP_OR:  res.out = a | b;
            OP_XOR: res.out = a ^ b;
            OP_SHL: res.out = (b >= 4'(DATA_W)) ? '0 : (a << b);
            OP_SHR: res.out = (b >= 4'(DATA_W)) ? '0 : (a >> b);
            OP_ROL: res.out = {a[DATA_W-2:0], a[DATA_W-1]};
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequencer around alu_core with a result accumulator.
// ALU_SEQ_ZERO_FLAG_EN adds a registered zero-result flag (rsp_zero).
module alu_seq
    import alu_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    alu_seq_if.slave  bus
);

    state_t            state;
    state_t            state_next;
    logic [SEL_W-1:0]  op_sel;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] rsp_out_q;
    logic              rsp_ov_q;
    logic [DATA_W-1:0] acc_q;
    alu_res_t          alu_res;
    logic              accept;

    assign accept = (state == ST_IDLE) && bus.cmd_valid;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (bus.cmd_valid) state_next = ST_EXEC;
            ST_EXEC: state_next = ST_RESP;
            ST_RESP: if (bus.rsp_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from state only
    always_comb begin
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state)
            ST_IDLE: bus.cmd_ready = 1'b1;
            ST_RESP: bus.rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand capture; A comes from the accumulator when cmd_acc is set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_sel <= '0;
            op_a   <= '0;
            op_b   <= '0;
        end else if (accept) begin
            op_sel <= bus.cmd_sel;
            op_a   <= bus.cmd_acc ? acc_q : bus.cmd_a;
            op_b   <= bus.cmd_b;
        end
    end

    alu_core u_core (
        .sel (op_sel),
        .a   (op_a),
        .b   (op_b),
        .res (alu_res)
    );

    // Result and accumulator capture, only at the end of EXEC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_out_q <= '0;
            rsp_ov_q  <= 1'b0;
            acc_q     <= '0;
        end else if (state == ST_EXEC) begin
            rsp_out_q <= alu_res.out;
            rsp_ov_q  <= alu_res.ov;
            acc_q     <= alu_res.out;
        end
    end

`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic rsp_zero_q;

    // Zero flag registered alongside the result
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    rsp_zero_q <= 1'b0;
        else if (state == ST_EXEC)  rsp_zero_q <= (alu_res.out == '0);
    end

    assign bus.rsp_zero = rsp_zero_q;
`endif

    assign bus.rsp_out = rsp_out_q;
    assign bus.rsp_ov  = rsp_ov_q;
    assign bus.acc     = acc_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq.
// Build with ALU_SEQ_ZERO_FLAG_EN to also check rsp_zero.
module tb_alu_seq;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    alu_seq_if bus ();

    alu_seq u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one command with rsp_ready high and check every phase of it
    task automatic run_cmd(input string tag, input logic [2:0] sel, input logic [3:0] a,
                           input logic [3:0] b, input logic use_acc,
                           input logic [3:0] exp_out, input logic exp_ov);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_sel   = sel;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_acc   = use_acc;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        check({tag, ".exec_cmd_ready"}, 8'(bus.cmd_ready), 8'd0);
        check({tag, ".exec_rsp_valid"}, 8'(bus.rsp_valid), 8'd0);
        @(posedge clk); #1;
        check({tag, ".rsp_valid"}, 8'(bus.rsp_valid), 8'd1);
        check({tag, ".rsp_out"},   8'(bus.rsp_out),   8'(exp_out));
        check({tag, ".rsp_ov"},    8'(bus.rsp_ov),    8'(exp_ov));
        check({tag, ".acc"},       8'(bus.acc),       8'(exp_out));
`ifdef ALU_SEQ_ZERO_FLAG_EN
        check({tag, ".rsp_zero"},  8'(bus.rsp_zero),  8'(exp_out == 4'd0));
`endif
        @(posedge clk); #1;
        check({tag, ".done_rsp_valid"}, 8'(bus.rsp_valid), 8'd0);
        check({tag, ".done_cmd_ready"}, 8'(bus.cmd_ready), 8'd1);
    endtask

    // Accumulator chain: ADD acc+3 six times from zero
    logic [3:0] chain_out [6] = '{4'd3, 4'd6, 4'd9, 4'd12, 4'd15, 4'd2};
    logic       chain_ov  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_sel   = '0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_acc   = 1'b0;
        bus.rsp_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst.cmd_ready", 8'(bus.cmd_ready), 8'd1);
        check("rst.rsp_valid", 8'(bus.rsp_valid), 8'd0);
        check("rst.acc",       8'(bus.acc),       8'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle.cmd_ready", 8'(bus.cmd_ready), 8'd1);
        check("idle.rsp_valid", 8'(bus.rsp_valid), 8'd0);
        check("idle.rsp_out",   8'(bus.rsp_out),   8'd0);

        // Basic opcodes
        run_cmd("add9_8",  OP_ADD, 4'd9,    4'd8,    1'b0, 4'b0001, 1'b1);
        run_cmd("sub3_5",  OP_SUB, 4'd3,    4'd5,    1'b0, 4'b1110, 1'b1);
        run_cmd("sub5_3",  OP_SUB, 4'd5,    4'd3,    1'b0, 4'b0010, 1'b0);
        run_cmd("or",      OP_OR,  4'b1010, 4'b0101, 1'b0, 4'b1111, 1'b0);
        run_cmd("xor",     OP_XOR, 4'b1100, 4'b1010, 1'b0, 4'b0110, 1'b0);
        run_cmd("shr_b4",  OP_SHR, 4'b1000, 4'd4,    1'b0, 4'b0000, 1'b0);
        run_cmd("shr_b2",  OP_SHR, 4'b1000, 4'd2,    1'b0, 4'b0010, 1'b0);
        run_cmd("shl_b4",  OP_SHL, 4'b0011, 4'd4,    1'b0, 4'b0000, 1'b0);
        run_cmd("shl_b1",  OP_SHL, 4'b0101, 4'd1,    1'b0, 4'b1010, 1'b0);
        run_cmd("rol",     OP_ROL, 4'b1001, 4'hF,    1'b0, 4'b0011, 1'b0);
        run_cmd("and_z",   OP_AND, 4'b1010, 4'b0101, 1'b0, 4'b0000, 1'b0);
        run_cmd("and_nz",  OP_AND, 4'b1110, 4'b0111, 1'b0, 4'b0110, 1'b0);
        // acc is 0110 here; cmd_a must be ignored when cmd_acc=1
        run_cmd("acc_sel", OP_ADD, 4'hF,    4'd1,    1'b1, 4'b0111, 1'b0);

        // Backpressure: SHL 0011<<2 held in RESP while a new command waits
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_sel   = OP_SHL;
        bus.cmd_a     = 4'b0011;
        bus.cmd_b     = 4'd2;
        bus.cmd_acc   = 1'b0;
        bus.rsp_ready = 1'b0;
        @(posedge clk); #1;
        bus.cmd_sel   = OP_XOR;
        bus.cmd_a     = 4'b0110;
        bus.cmd_b     = 4'b0011;
        @(posedge clk); #1;
        check("bp.rsp_valid", 8'(bus.rsp_valid), 8'd1);
        check("bp.rsp_out",   8'(bus.rsp_out),   8'b1100);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("bp.hold%0d.rsp_out", i),   8'(bus.rsp_out),   8'b1100);
            check($sformatf("bp.hold%0d.rsp_valid", i), 8'(bus.rsp_valid), 8'd1);
            check($sformatf("bp.hold%0d.cmd_ready", i), 8'(bus.cmd_ready), 8'd0);
            check($sformatf("bp.hold%0d.acc", i),       8'(bus.acc),       8'b1100);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp.rel.rsp_valid", 8'(bus.rsp_valid), 8'd0);
        check("bp.rel.cmd_ready", 8'(bus.cmd_ready), 8'd1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        check("bp.next.accepted", 8'(bus.cmd_ready), 8'd0);
        @(posedge clk); #1;
        check("bp.next.rsp_valid", 8'(bus.rsp_valid), 8'd1);
        check("bp.next.rsp_out",   8'(bus.rsp_out),   8'b0101);
        check("bp.next.acc",       8'(bus.acc),       8'b0101);
        @(posedge clk); #1;
        check("bp.next.done", 8'(bus.cmd_ready), 8'd1);

        // Reset in the middle of RESP
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_sel   = OP_ADD;
        bus.cmd_a     = 4'd1;
        bus.cmd_b     = 4'd2;
        bus.rsp_ready = 1'b0;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(posedge clk); #1;
        check("mid.rsp_valid", 8'(bus.rsp_valid), 8'd1);
        check("mid.acc",       8'(bus.acc),       8'd3);
        #1 rst = 1'b1;
        #1;
        check("arst.rsp_valid", 8'(bus.rsp_valid), 8'd0);
        check("arst.cmd_ready", 8'(bus.cmd_ready), 8'd1);
        check("arst.acc",       8'(bus.acc),       8'd0);
        check("arst.rsp_out",   8'(bus.rsp_out),   8'd0);
        check("arst.rsp_ov",    8'(bus.rsp_ov),    8'd0);
        @(negedge clk);
        rst = 1'b0;

        // Running sum through the accumulator
        for (int i = 0; i < 6; i++)
            run_cmd($sformatf("chain%0d", i), OP_ADD, 4'hF, 4'd3, 1'b1, chain_out[i], chain_ov[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
